// File: rtl/stream_comp_source.sv
// CFDF source actor: emits (cmd, len) header pairs, then the matching run of data tokens.
// Firings follow the enable/invoke/FC handshake and respect downstream FIFO occupancy.
module stream_comp_source #(
  parameter int width       = 5,
  parameter int buffer_size = 10,
  parameter int num_cmds    = 3,
  parameter int data_depth  = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_en,
  input  logic [1:0]                    load_sel,
  input  logic [$clog2(data_depth)-1:0] load_addr,
  input  logic [width-1:0]              load_data,
  input  logic [1:0]                    next_mode_in,
  input  logic                          invoke,
  input  logic [$clog2(buffer_size)-1:0] pop_cmd,
  input  logic [$clog2(buffer_size)-1:0] pop_len,
  input  logic [$clog2(buffer_size)-1:0] pop_data,
  output logic                          enable,
  output logic                          wr_en_cmd_len,
  output logic [width-1:0]              cmd_out,
  output logic [width-1:0]              len_out,
  output logic                          wr_en_data,
  output logic [width-1:0]              data_out,
  output logic                          FC,
  output logic [1:0]                    next_mode_out
);

  localparam int PW = $clog2(buffer_size);
  localparam int AW = $clog2(data_depth);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(num_cmds) + 1;
  localparam int DW = $clog2(data_depth) + 1;
  localparam int HA = (num_cmds > 1) ? $clog2(num_cmds) : 1;
  localparam int DA = (data_depth > 1) ? AW : 1;
  // Wide enough that data_idx + cur_len cannot wrap.
  localparam int SW = ((DW > width) ? DW : width) + 1;

  localparam logic [1:0] M_HDR  = 2'b00;
  localparam logic [1:0] M_DATA = 2'b01;
  localparam logic [1:0] M_DONE = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_HDR, WR_DATA, FIN} state_t;

  state_t           state, state_d;
  logic             fire_hdr, fire_hdr_d;
  logic [HW-1:0]    hdr_idx, hdr_idx_d;
  logic [DW-1:0]    data_idx, data_idx_d;
  logic [width-1:0] cur_len, cur_len_d;
  logic [width-1:0] rem, rem_d;
  logic             wr_cl_d, wr_d_d, fc_d;
  logic [width-1:0] cmd_d, len_d, data_d;
  logic [1:0]       mode_d;

  logic [width-1:0] cmd_mem  [num_cmds];
  logic [width-1:0] len_mem  [num_cmds];
  logic [width-1:0] data_mem [data_depth];

  logic [CW-1:0]    room;
  logic             hdr_ok, data_ok;

  // Free slots in the data FIFO; an occupancy above depth reads as full.
  always_comb begin
    room = '0;
    if ({1'b0, pop_data} <= CW'(buffer_size))
      room = CW'(buffer_size) - {1'b0, pop_data};
  end

  assign hdr_ok  = (hdr_idx < HW'(num_cmds)) &&
                   ({1'b0, pop_cmd} < CW'(buffer_size)) &&
                   ({1'b0, pop_len} < CW'(buffer_size));
  assign data_ok = (SW'(cur_len) <= SW'(room)) &&
                   ((SW'(data_idx) + SW'(cur_len)) <= SW'(data_depth));

  always_comb begin
    enable = 1'b0;
    case (next_mode_in)
      M_HDR:   enable = hdr_ok;
      M_DATA:  enable = data_ok;
      default: enable = 1'b0;
    endcase
  end

  // Tables are not reset; writes land only between firings.
  always_ff @(posedge clk) begin
    if (load_en && state == IDLE) begin
      case (load_sel)
        2'b00: if (load_addr < AW'(num_cmds)) cmd_mem[load_addr[HA-1:0]] <= load_data;
        2'b01: if (load_addr < AW'(num_cmds)) len_mem[load_addr[HA-1:0]] <= load_data;
        2'b10: if ({1'b0, load_addr} < (AW+1)'(data_depth)) data_mem[load_addr[DA-1:0]] <= load_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state;
    fire_hdr_d = fire_hdr;
    hdr_idx_d  = hdr_idx;
    data_idx_d = data_idx;
    cur_len_d  = cur_len;
    rem_d      = rem;
    wr_cl_d    = 1'b0;
    wr_d_d     = 1'b0;
    fc_d       = 1'b0;
    cmd_d      = cmd_out;
    len_d      = len_out;
    data_d     = data_out;
    mode_d     = next_mode_out;
    case (state)
      IDLE: begin
        if (invoke && enable) begin
          if (next_mode_in == M_HDR) begin
            fire_hdr_d = 1'b1;
            state_d    = WR_HDR;
          end else begin
            fire_hdr_d = 1'b0;
            rem_d      = cur_len;
            state_d    = (cur_len == '0) ? FIN : WR_DATA;
          end
        end
      end
      WR_HDR: begin
        wr_cl_d   = 1'b1;
        cmd_d     = cmd_mem[hdr_idx[HA-1:0]];
        len_d     = len_mem[hdr_idx[HA-1:0]];
        cur_len_d = len_mem[hdr_idx[HA-1:0]];
        hdr_idx_d = hdr_idx + HW'(1);
        state_d   = FIN;
      end
      WR_DATA: begin
        wr_d_d     = 1'b1;
        data_d     = data_mem[data_idx[DA-1:0]];
        data_idx_d = data_idx + DW'(1);
        rem_d      = rem - width'(1);
        if (rem == width'(1)) state_d = FIN;
      end
      FIN: begin
        fc_d    = 1'b1;
        mode_d  = fire_hdr ? M_DATA : ((hdr_idx == HW'(num_cmds)) ? M_DONE : M_HDR);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      fire_hdr      <= 1'b0;
      hdr_idx       <= '0;
      data_idx      <= '0;
      cur_len       <= '0;
      rem           <= '0;
      wr_en_cmd_len <= 1'b0;
      wr_en_data    <= 1'b0;
      FC            <= 1'b0;
      cmd_out       <= '0;
      len_out       <= '0;
      data_out      <= '0;
      next_mode_out <= M_HDR;
    end else begin
      state         <= state_d;
      fire_hdr      <= fire_hdr_d;
      hdr_idx       <= hdr_idx_d;
      data_idx      <= data_idx_d;
      cur_len       <= cur_len_d;
      rem           <= rem_d;
      wr_en_cmd_len <= wr_cl_d;
      wr_en_data    <= wr_d_d;
      FC            <= fc_d;
      cmd_out       <= cmd_d;
      len_out       <= len_d;
      data_out      <= data_d;
      next_mode_out <= mode_d;
    end
  end

endmodule

// File: tb/tb_stream_comp_source.sv
// Directed bench for stream_comp_source: header/data firings, backpressure, full run, reset, load guard.
module tb_stream_comp_source;

  logic       clk, rst;
  logic       load_en;
  logic [1:0] load_sel;
  logic [3:0] load_addr;
  logic [4:0] load_data;
  logic [1:0] next_mode_in;
  logic       invoke;
  logic [3:0] pop_cmd, pop_len, pop_data;
  logic       enable, wr_en_cmd_len, wr_en_data, FC;
  logic [4:0] cmd_out, len_out, data_out;
  logic [1:0] next_mode_out;

  int vectors = 0;
  int miscompares = 0;

  stream_comp_source #(.width(5), .buffer_size(10), .num_cmds(3), .data_depth(15)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr),
    .load_data(load_data), .next_mode_in(next_mode_in), .invoke(invoke),
    .pop_cmd(pop_cmd), .pop_len(pop_len), .pop_data(pop_data), .enable(enable),
    .wr_en_cmd_len(wr_en_cmd_len), .cmd_out(cmd_out), .len_out(len_out),
    .wr_en_data(wr_en_data), .data_out(data_out), .FC(FC), .next_mode_out(next_mode_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [3:0] addr, input logic [4:0] val);
    load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = val;
    step();
    load_en = 1'b0;
  endtask

  task automatic hdr_fire(input int c, input int l);
    next_mode_in = 2'b00;
    #1;
    chk("hdr_enable", enable, 1);
    invoke = 1'b1;
    step();
    invoke = 1'b0;
    chk("hdr_no_early_wr", wr_en_cmd_len, 0);
    step();
    chk("hdr_wr", wr_en_cmd_len, 1);
    chk("hdr_cmd", cmd_out, c);
    chk("hdr_len", len_out, l);
    chk("hdr_fc_early", FC, 0);
    step();
    chk("hdr_fc", FC, 1);
    chk("hdr_wr_drop", wr_en_cmd_len, 0);
    chk("hdr_mode", next_mode_out, 2'b01);
    step();
    chk("hdr_fc_width", FC, 0);
  endtask

  task automatic data_fire(input int n, input int first, input logic [1:0] exp_mode);
    next_mode_in = 2'b01;
    #1;
    chk("dat_enable", enable, 1);
    invoke = 1'b1;
    step();
    invoke = 1'b0;
    chk("dat_no_early_wr", wr_en_data, 0);
    chk("dat_no_early_fc", FC, 0);
    for (int k = 0; k < n; k++) begin
      step();
      chk("dat_wr", wr_en_data, 1);
      chk("dat_val", data_out, first + k);
      chk("dat_fc_early", FC, 0);
    end
    step();
    chk("dat_fc", FC, 1);
    chk("dat_wr_drop", wr_en_data, 0);
    chk("dat_mode", next_mode_out, exp_mode);
    step();
    chk("dat_fc_width", FC, 0);
  endtask

  task automatic idle_invoke(input logic [1:0] mode);
    next_mode_in = mode;
    invoke = 1'b1;
    step();
    invoke = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("blk_wr_hdr", wr_en_cmd_len, 0);
      chk("blk_wr_dat", wr_en_data, 0);
      chk("blk_fc", FC, 0);
    end
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_sel = 2'b00; load_addr = '0; load_data = '0;
    next_mode_in = 2'b00; invoke = 1'b0; pop_cmd = '0; pop_len = '0; pop_data = '0;
    #2 rst = 1'b0;
    step(); step();
    chk("rst_wr_hdr", wr_en_cmd_len, 0);
    chk("rst_wr_dat", wr_en_data, 0);
    chk("rst_fc", FC, 0);
    chk("rst_cmd", cmd_out, 0);
    chk("rst_len", len_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_mode", next_mode_out, 2'b00);
    rst = 1'b1;
    step();

    load(2'b00, 0, 3); load(2'b00, 1, 5); load(2'b00, 2, 7);
    load(2'b01, 0, 4); load(2'b01, 1, 5); load(2'b01, 2, 6);
    for (int i = 0; i < 15; i++) load(2'b10, 4'(i), 5'(i + 1));

    next_mode_in = 2'b10; #1; chk("en_done", enable, 0);
    next_mode_in = 2'b11; #1; chk("en_mode11", enable, 0);
    next_mode_in = 2'b01; #1; chk("en_data_len0", enable, 1);

    // Header 0 then its 4 data tokens.
    hdr_fire(3, 4);
    data_fire(4, 1, 2'b00);

    // Header 1, then data backpressure at the boundary.
    hdr_fire(5, 5);
    next_mode_in = 2'b01; pop_data = 4'd6; #1;
    chk("bp_en_off", enable, 0);
    idle_invoke(2'b01);
    pop_data = 4'd5; #1;
    chk("bp_en_on", enable, 1);
    data_fire(5, 5, 2'b00);
    pop_data = 4'd0;

    // Header FIFO full thresholds.
    next_mode_in = 2'b00;
    pop_cmd = 4'd10; #1; chk("cmd_full", enable, 0);
    pop_cmd = 4'd9;  #1; chk("cmd_room", enable, 1);
    pop_len = 4'd10; #1; chk("len_full", enable, 0);
    pop_cmd = 4'd0; pop_len = 4'd0;

    // Last header and data run completes the stream.
    hdr_fire(7, 6);
    data_fire(6, 10, 2'b10);
    for (int m = 0; m < 4; m++) begin
      next_mode_in = 2'(m); #1;
      chk("end_en_off", enable, 0);
    end
    idle_invoke(2'b01);
    idle_invoke(2'b00);

    // Asynchronous reset, first while idle then in the middle of a firing.
    rst = 1'b0; #1;
    chk("arst_mode", next_mode_out, 2'b00);
    chk("arst_fc", FC, 0);
    @(posedge clk); #1 rst = 1'b1;
    next_mode_in = 2'b00; #1;
    chk("arst_en_hdr", enable, 1);
    invoke = 1'b1; step(); invoke = 1'b0;
    step();
    chk("mid_wr", wr_en_cmd_len, 1);
    chk("mid_cmd", cmd_out, 3);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_wr", wr_en_cmd_len, 0);
    chk("mid_rst_cmd", cmd_out, 0);
    chk("mid_rst_len", len_out, 0);
    chk("mid_rst_fc", FC, 0);
    chk("mid_rst_mode", next_mode_out, 2'b00);
    @(posedge clk); #1 rst = 1'b1;
    step();
    chk("abort_no_fc1", FC, 0);
    step();
    chk("abort_no_fc2", FC, 0);
    hdr_fire(3, 4);

    // Zero-length header with a load attempted during its firing.
    rst = 1'b0; step(); rst = 1'b1; step();
    load(2'b01, 0, 0);
    next_mode_in = 2'b00; #1;
    invoke = 1'b1; step(); invoke = 1'b0;
    load_en = 1'b1; load_sel = 2'b00; load_addr = 4'd1; load_data = 5'd31;
    step();
    chk("z_wr", wr_en_cmd_len, 1);
    chk("z_cmd", cmd_out, 3);
    chk("z_len", len_out, 0);
    step();
    load_en = 1'b0;
    chk("z_fc", FC, 1);
    step();
    data_fire(0, 0, 2'b00);
    hdr_fire(5, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_comp_source.md
Name: stream_comp_source

Overview:
CFDF source actor that produces the token streams consumed by the stream-compute actor. It writes (command, length) header pairs into the command and length FIFOs, then writes the matching run of data tokens into the data FIFO. Stimulus tables are loaded through a simple load port before the run. The block uses the same enable/invoke/FC firing handshake as the other actors, and honours FIFO occupancy so it never overflows a downstream FIFO.

Parameters:
width, 5, token width for command, length and data
buffer_size, 10, depth of each downstream FIFO; occupancy ports are log2(buffer_size) bits
num_cmds, 3, number of header entries in the command/length tables
data_depth, 15, number of entries in the data table

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
load_en  input  1  table write strobe; honoured only in IDLE
load_sel  input  2  table select: 00 command, 01 length, 10 data, 11 ignored
load_addr  input  log2(data_depth)  table index; out-of-range writes ignored
load_data  input  width  value to store
next_mode_in  input  2  requested mode: 00 HDR, 01 DATA, 10 DONE
invoke  input  1  start one firing of next_mode_in
pop_cmd  input  log2(buffer_size)  command FIFO occupancy
pop_len  input  log2(buffer_size)  length FIFO occupancy
pop_data  input  log2(buffer_size)  data FIFO occupancy
enable  output  1  combinational: firing of next_mode_in is allowed
wr_en_cmd_len  output  1  shared write strobe for the command and length FIFOs
cmd_out  output  width  command token
len_out  output  width  length token
wr_en_data  output  1  data FIFO write strobe
data_out  output  width  data token
FC  output  1  one-cycle firing-complete pulse
next_mode_out  output  2  mode for the next firing

Behaviour:
- Reset: all registered outputs go to 0 and next_mode_out goes to 00 (HDR). hdr_idx, data_idx and cur_len clear, and the FSM returns to IDLE. Tables are not cleared. Reset asserted mid-firing aborts the firing immediately and no FC is issued.
- FSM states: IDLE, WR_HDR, WR_DATA, FIN.
- Enable, HDR mode: hdr_idx < num_cmds, pop_cmd < buffer_size and pop_len < buffer_size.
- Enable, DATA mode:
  - cur_len is the length latched at the last header write.
  - Requires buffer_size - pop_data >= cur_len and data_idx + cur_len <= data_depth.
  - cur_len = 0 is enabled: the firing produces no writes.
- Enable, DONE or 11: enable = 0.
- Invoke handling: invoke is sampled at a rising edge only when the FSM is in IDLE and enable = 1. Otherwise it is ignored with no state change.
- HDR firing (invoke at edge t):
  - Edge t+1 (cycle 1): wr_en_cmd_len = 1, cmd_out = cmd_mem[hdr_idx], len_out = len_mem[hdr_idx]. cur_len latches len_mem[hdr_idx]; hdr_idx increments.
  - Cycle 2: FC = 1 and next_mode_out = 01. FSM returns to IDLE.
- DATA firing:
  - Cycles 1..cur_len: wr_en_data = 1, data_out = data_mem[data_idx], data_idx increments once per cycle. Writes are back-to-back, one token per cycle.
  - Cycle cur_len+1: FC = 1.
  - next_mode_out = 10 (DONE) if hdr_idx == num_cmds, else 00.
  - If cur_len = 0, FC is asserted in cycle 1.
- Strobe widths: write strobes are never asserted outside a firing. FC is exactly one cycle wide.
- Widths: counters are log2(num_cmds)+1 and log2(data_depth)+1 bits. The capacity comparison is done in log2(buffer_size)+1 bits, so pop = buffer_size is not misread.
- Load during a firing: the write is dropped and the tables are unchanged.
- Out-of-range cur_len: if cur_len > data_depth, enable stays 0 in DATA mode, which stalls the source (a deliberate configuration error).

Test Plan:
1. Reset: rst = 0 mid-run -> all outputs 0, next_mode_out = 00, FC = 0 on the same edge without waiting for clk. Release, then HDR firing -> emits cmd_mem[0] again.
2. Header firing: load cmd {3,5,7}, len {4,5,6}, data 1..15; pops 0; next_mode_in = 00, invoke for one cycle -> one cycle later wr_en_cmd_len = 1, cmd_out = 3, len_out = 4; next cycle FC = 1, next_mode_out = 01.
3. Data firing: next_mode_in = 01, invoke -> wr_en_data high for 4 consecutive cycles with data_out = 1, 2, 3, 4; FC on the 5th cycle; next_mode_out = 00.
4. Backpressure: in DATA mode with cur_len = 5 and pop_data = 6 -> enable = 0, and invoke produces no writes. Set pop_data = 5 -> enable = 1, and the firing emits 5, 6, 7, 8, 9.
5. Full run: alternate HDR/DATA three times with the tables from scenario 2 -> 15 data tokens 1..15 in order. After the last FC, next_mode_out = 10 and enable = 0 for all modes. A further invoke produces no writes.
6. Zero length and load guard: len_mem[0] = 0 -> DATA firing gives FC one cycle after invoke with no wr_en_data. Issue load_en during an HDR firing -> the targeted table entry is unchanged on readback via a subsequent firing.
